// File: rtl/pc_unit.sv
// Program counter with trap/return support and a circular return-address stack.
// All state advances on the rising clock edge; the priority of the control inputs is resolved in one combinational block.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h80),
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call_valid,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret_valid,
    input  logic             trap,
    input  logic             mret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);

    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_m1;
    logic [PTR_W:0]   count;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_next;
    logic [PTR_W-1:0] top_next;
    logic [PTR_W:0]   count_next;
    logic             miss_next;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic [WIDTH-1:0] ras_wdata;

    assign pc_plus = pc + STEP_W;
    assign top_m1  = top - PTR_W'(1);

    // top points at the next free slot, so a push into a full stack lands on the oldest entry.
    always_comb begin
        pc_next    = pc_plus;
        epc_next   = epc;
        top_next   = top;
        count_next = count;
        miss_next  = 1'b0;
        ras_we     = 1'b0;
        ras_waddr  = top;
        ras_wdata  = pc_plus;
        if (trap) begin
            pc_next  = TRAP_VECTOR;
            epc_next = pc;
        end else if (mret) begin
            pc_next = epc;
        end else if (redirect_valid) begin
            pc_next = word_align(redirect_target);
        end else if (stall) begin
            pc_next   = pc;
            miss_next = ret_miss;
        end else if (call_valid && ret_valid) begin
            pc_next = word_align(call_target);
            ras_we  = 1'b1;
            if (count == '0) begin
                top_next   = top + PTR_W'(1);
                count_next = (PTR_W+1)'(1);
            end else begin
                ras_waddr = top_m1;
            end
        end else if (call_valid) begin
            pc_next  = word_align(call_target);
            ras_we   = 1'b1;
            top_next = top + PTR_W'(1);
            if (count != DEPTH_C) count_next = count + (PTR_W+1)'(1);
        end else if (ret_valid) begin
            if (count != '0) begin
                pc_next    = ras_mem[top_m1];
                top_next   = top_m1;
                count_next = count - (PTR_W+1)'(1);
            end else begin
                miss_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            epc       <= '0;
            top       <= '0;
            count     <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ret_miss  <= 1'b0;
        end else begin
            pc        <= pc_next;
            epc       <= epc_next;
            top       <= top_next;
            count     <= count_next;
            ras_empty <= (count_next == '0);
            ras_full  <= (count_next == DEPTH_C);
            ret_miss  <= miss_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ras_we) ras_mem[ras_waddr] <= ras_wdata;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit default instance and an 8-bit instance for wrap and reset-override cases.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, call_valid, ret_valid, trap, mret;
    logic [31:0] redirect_target, call_target;
    logic [31:0] pc, pc_plus, epc;
    logic        ras_empty, ras_full, ret_miss;

    logic        reset8, stall8, redirect_valid8, call_valid8, ret_valid8, trap8, mret8;
    logic [7:0]  redirect_target8, call_target8;
    logic [7:0]  pc8, pc_plus8, epc8;
    logic        ras_empty8, ras_full8, ret_miss8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call_valid(call_valid), .call_target(call_target),
        .ret_valid(ret_valid), .trap(trap), .mret(mret),
        .pc(pc), .pc_plus(pc_plus), .epc(epc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ret_miss(ret_miss)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h10)) u_dut8 (
        .clk(clk), .reset(reset8), .stall(stall8),
        .redirect_valid(redirect_valid8), .redirect_target(redirect_target8),
        .call_valid(call_valid8), .call_target(call_target8),
        .ret_valid(ret_valid8), .trap(trap8), .mret(mret8),
        .pc(pc8), .pc_plus(pc_plus8), .epc(epc8),
        .ras_empty(ras_empty8), .ras_full(ras_full8), .ret_miss(ret_miss8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; redirect_valid = 0; call_valid = 0; ret_valid = 0;
        trap = 0; mret = 0; redirect_target = '0; call_target = '0;
    endtask

    initial begin
        idle_inputs();
        reset8 = 1; stall8 = 0; redirect_valid8 = 0; call_valid8 = 0; ret_valid8 = 0;
        trap8 = 0; mret8 = 0; redirect_target8 = '0; call_target8 = '0;

        // Reset and sequential fetch
        reset = 1; tick();
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_empty", ras_empty, 1'b1);
        check("rst_full", ras_full, 1'b0);
        check("rst_miss", ret_miss, 1'b0);
        reset = 0;
        tick(); check("seq_4", pc, 32'h4);
        tick(); check("seq_8", pc, 32'h8);
        tick(); check("seq_c", pc, 32'hC);
        check("pc_plus_10", pc_plus, 32'h10);
        tick(); check("seq_10", pc, 32'h10);

        // Single call and return
        call_valid = 1; call_target = 32'h200; tick(); idle_inputs();
        check("call_pc", pc, 32'h200);
        check("call_nonempty", ras_empty, 1'b0);
        tick(); check("call_seq", pc, 32'h204);
        ret_valid = 1; tick(); idle_inputs();
        check("ret_pc", pc, 32'h14);
        check("ret_empty", ras_empty, 1'b1);
        check("ret_nomiss", ret_miss, 1'b0);

        // Five calls into a 4-deep stack, then five returns
        redirect_valid = 1; redirect_target = 32'h0; tick(); idle_inputs();
        check("redir_0", pc, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            call_valid = 1; call_target = 32'(i) << 8; tick(); idle_inputs();
            check("ncall_pc", pc, 32'(i) << 8);
            if (i == 3) check("ncall_notfull", ras_full, 1'b0);
            if (i >= 4) check("ncall_full", ras_full, 1'b1);
        end
        ret_valid = 1; tick(); check("nret_404", pc, 32'h404); check("nret_notfull", ras_full, 1'b0);
        tick(); check("nret_304", pc, 32'h304);
        tick(); check("nret_204", pc, 32'h204);
        tick(); check("nret_104", pc, 32'h104); check("nret_empty", ras_empty, 1'b1);
        check("nret_nomiss", ret_miss, 1'b0);
        tick(); idle_inputs();
        check("miss_pc", pc, 32'h108);
        check("miss_flag", ret_miss, 1'b1);
        tick();
        check("miss_clear", ret_miss, 1'b0);
        check("miss_seq", pc, 32'h10C);

        // Trap under stall, then mret
        redirect_valid = 1; redirect_target = 32'h40; tick(); idle_inputs();
        check("redir_40", pc, 32'h40);
        stall = 1; trap = 1; tick(); idle_inputs();
        check("trap_pc", pc, 32'h80);
        check("trap_epc", epc, 32'h40);
        mret = 1; tick(); idle_inputs();
        check("mret_pc", pc, 32'h40);
        check("mret_epc", epc, 32'h40);

        // Redirect overrides stall; stall holds pc and ret_miss
        stall = 1; redirect_valid = 1; redirect_target = 32'h123; tick(); idle_inputs();
        check("redir_stall", pc, 32'h120);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", pc, 32'h120);
        end
        idle_inputs();
        ret_valid = 1; tick(); idle_inputs();
        check("miss2_pc", pc, 32'h124);
        check("miss2_flag", ret_miss, 1'b1);
        stall = 1; tick(); idle_inputs();
        check("stall_miss_hold", ret_miss, 1'b1);
        check("stall_pc_hold", pc, 32'h124);
        tick();
        check("miss2_clear", ret_miss, 1'b0);
        check("miss2_seq", pc, 32'h128);

        // Simultaneous call and return
        call_valid = 1; ret_valid = 1; call_target = 32'h300; tick(); idle_inputs();
        check("cr_empty_pc", pc, 32'h300);
        check("cr_empty_push", ras_empty, 1'b0);
        call_valid = 1; ret_valid = 1; call_target = 32'h400; tick(); idle_inputs();
        check("cr_repl_pc", pc, 32'h400);
        ret_valid = 1; tick(); idle_inputs();
        check("cr_ret_pc", pc, 32'h304);
        check("cr_ret_empty", ras_empty, 1'b1);

        // Reset beats trap
        trap = 1; reset = 1; tick(); idle_inputs();
        check("rst_trap_pc", pc, 32'h0);
        check("rst_trap_epc", epc, 32'h0);

        // 8-bit instance: wrap and reset beats call
        reset8 = 0;
        check("w8_rst_pc", pc8, 8'h10);
        redirect_valid8 = 1; redirect_target8 = 8'hFC; tick(); redirect_valid8 = 0;
        check("w8_pc_fc", pc8, 8'hFC);
        check("w8_plus_wrap", pc_plus8, 8'h00);
        tick(); check("w8_wrap", pc8, 8'h00);
        call_valid8 = 1; call_target8 = 8'h40; tick(); call_valid8 = 0;
        check("w8_call_pc", pc8, 8'h40);
        check("w8_call_nonempty", ras_empty8, 1'b0);
        call_valid8 = 1; call_target8 = 8'h80; reset8 = 1; tick();
        call_valid8 = 0; reset8 = 0;
        check("w8_rst_call_pc", pc8, 8'h10);
        check("w8_rst_call_empty", ras_empty8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
